// File: rtl/pipe_slice_pkg.sv
// pipe_slice_pkg: shared types for the pipe_slice_multi register slice.
// Exports psm_mode_t and psm_cap() (beats held per stage for a mode).
package pipe_slice_pkg;

  typedef enum logic [1:0] {
    PSM_BYPASS,
    PSM_HALF,
    PSM_FULL
  } psm_mode_t;

  function automatic int psm_cap(psm_mode_t m);
    case (m)
      PSM_FULL: return 2;
      PSM_HALF: return 1;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slice_multi_if.sv
// pipe_slice_multi_if: upstream din/valid/ready and downstream dout/valid/ready.
// slave = the slice (consumes din, produces dout); master = its environment.
interface pipe_slice_multi_if #(
  parameter int SIZE = 64
);
  logic [SIZE-1:0] din;
  logic            din_vld;
  logic            din_rdy;
  logic [SIZE-1:0] dout;
  logic            dout_vld;
  logic            dout_rdy;

  modport master (
    output din, din_vld, dout_rdy,
    input  din_rdy, dout, dout_vld
  );

  modport slave (
    input  din, din_vld, dout_rdy,
    output din_rdy, dout, dout_vld
  );
endinterface

// File: rtl/pipe_slice_stage.sv
// pipe_slice_stage: one valid/ready slice, FULL (main+skid) or HALF (1 reg).
// Ports: clk, rst, in_data/in_vld/in_rdy upstream, out_* downstream.
module pipe_slice_stage
  import pipe_slice_pkg::*;
#(
  parameter int        SIZE = 64,
  parameter psm_mode_t MODE = PSM_FULL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_vld,
  output logic            in_rdy,
  output logic [SIZE-1:0] out_data,
  output logic            out_vld,
  input  logic            out_rdy
);

  logic            main_vld_q, main_vld_d;
  logic [SIZE-1:0] main_q, main_d;
  logic            skid_vld_q, skid_vld_d;
  logic [SIZE-1:0] skid_q, skid_d;
  logic            in_fire;

  // Ready comes from flops only; rst gating keeps it low in reset
  // and lets it rise as soon as reset releases.
  if (MODE == PSM_FULL) begin : g_rdy_full
    assign in_rdy = ~rst & ~skid_vld_q;
  end else begin : g_rdy_half
    assign in_rdy = ~rst & ~main_vld_q;
  end

  assign in_fire  = in_vld & in_rdy;
  assign out_vld  = main_vld_q;
  assign out_data = main_q;

  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (MODE == PSM_FULL) begin
      if (skid_vld_q) begin
        // in_rdy is low here, only drain
        if (out_rdy) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end
      end else if (main_vld_q && !out_rdy) begin
        if (in_fire) begin
          skid_d     = in_data;
          skid_vld_d = 1'b1;
        end
      end else begin
        // main empty or draining: reload it
        main_vld_d = in_fire;
        if (in_fire) main_d = in_data;
      end
    end else begin
      if (in_fire) begin
        main_vld_d = 1'b1;
        main_d     = in_data;
      end else if (main_vld_q && out_rdy) begin
        main_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_q     <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/pipe_slice_multi.sv
// pipe_slice_multi: N_STAGE chained valid/ready slices, or bypass wiring.
// Ports: clk, rst, bus (slave: din/dout handshakes), level (beats held).
module pipe_slice_multi
  import pipe_slice_pkg::*;
#(
  parameter int        SIZE    = 64,
  parameter int        N_STAGE = 2,
  parameter psm_mode_t MODE    = PSM_FULL,
  parameter int        LVL_W   =
    $clog2(psm_cap(PSM_FULL) * N_STAGE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  pipe_slice_multi_if.slave bus,
  output logic [LVL_W-1:0]  level
);

  logic [LVL_W-1:0] level_q, level_d;
  logic             in_fire;
  logic             out_fire;

  if (MODE == PSM_BYPASS) begin : g_byp
    assign bus.dout     = rst ? '0 : bus.din;
    assign bus.dout_vld = ~rst & bus.din_vld;
    assign bus.din_rdy  = ~rst & bus.dout_rdy;
  end else begin : g_chain
    logic [SIZE-1:0] d_s [N_STAGE+1];
    logic [N_STAGE:0] v_s;
    logic [N_STAGE:0] r_s;

    assign d_s[0]       = bus.din;
    assign v_s[0]       = bus.din_vld;
    assign bus.din_rdy  = r_s[0];
    assign bus.dout     = d_s[N_STAGE];
    assign bus.dout_vld = v_s[N_STAGE];
    assign r_s[N_STAGE] = bus.dout_rdy;

    for (genvar i = 0; i < N_STAGE; i++) begin : g_stage
      pipe_slice_stage #(
        .SIZE (SIZE),
        .MODE (MODE)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .in_data  (d_s[i]),
        .in_vld   (v_s[i]),
        .in_rdy   (r_s[i]),
        .out_data (d_s[i+1]),
        .out_vld  (v_s[i+1]),
        .out_rdy  (r_s[i+1])
      );
    end
  end

  assign in_fire  = bus.din_vld & bus.din_rdy;
  assign out_fire = bus.dout_vld & bus.dout_rdy;

  always_comb begin
    level_d = level_q;
    if (MODE != PSM_BYPASS) begin
      case ({in_fire, out_fire})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign level = level_q;

endmodule

// File: tb/tb_pipe_slice_multi.sv
// tb_pipe_slice_multi: directed + random checks of FULL/HALF/BYPASS slices.
// Scoreboard queues model in-flight beats; level is checked against depth.
module tb_pipe_slice_multi;
  import pipe_slice_pkg::*;

  logic clk;
  logic rst;
  logic [2:0] f_lvl;
  logic [1:0] h_lvl;
  logic [1:0] b_lvl;

  pipe_slice_multi_if #(.SIZE(64)) fi ();
  pipe_slice_multi_if #(.SIZE(16)) hi ();
  pipe_slice_multi_if #(.SIZE(16)) bi ();

  pipe_slice_multi #(
    .SIZE(64), .N_STAGE(2), .MODE(PSM_FULL)
  ) u_full (
    .clk(clk), .rst(rst), .bus(fi), .level(f_lvl)
  );

  pipe_slice_multi #(
    .SIZE(16), .N_STAGE(1), .MODE(PSM_HALF)
  ) u_half (
    .clk(clk), .rst(rst), .bus(hi), .level(h_lvl)
  );

  pipe_slice_multi #(
    .SIZE(16), .N_STAGE(1), .MODE(PSM_BYPASS)
  ) u_byp (
    .clk(clk), .rst(rst), .bus(bi), .level(b_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int cyc;
  logic [63:0] qf[$];
  logic [15:0] hq[$];
  int f_in_n, f_out_n, f_first_in, f_first_out, f_last_out;
  int f_peak;
  int h_in_n, h_out_n;
  logic f_hold;
  logic [63:0] f_hold_d;
  logic [63:0] f_last_d;
  logic [7:0] pat;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluate handshakes just after inputs settle, then advance one cycle.
  task automatic tick();
    #1;
    if (f_hold) begin
      chk("f_hold_vld", 64'(fi.dout_vld), 64'd1);
      chk("f_hold_dout", fi.dout, f_hold_d);
    end
    chk("f_level", 64'(f_lvl), 64'(qf.size()));
    if (int'(f_lvl) > f_peak) f_peak = int'(f_lvl);
    if (fi.dout_vld && fi.dout_rdy) begin
      if (qf.size() == 0) begin
        chk("f_extra_beat", 64'(fi.dout_vld), 64'd0);
      end else begin
        chk("f_dout", fi.dout, qf.pop_front());
      end
      if (f_out_n == 0) f_first_out = cyc;
      f_last_out = cyc;
      f_last_d = fi.dout;
      f_out_n++;
    end
    if (fi.din_vld && fi.din_rdy) begin
      qf.push_back(fi.din);
      if (f_in_n == 0) f_first_in = cyc;
      f_in_n++;
    end
    f_hold = fi.dout_vld && !fi.dout_rdy;
    f_hold_d = fi.dout;

    chk("h_level", 64'(h_lvl), 64'(hq.size()));
    if (hi.dout_vld && hi.dout_rdy) begin
      if (hq.size() == 0) begin
        chk("h_extra_beat", 64'(hi.dout_vld), 64'd0);
      end else begin
        chk("h_dout", 64'(hi.dout), 64'(hq.pop_front()));
      end
      h_out_n++;
    end
    if (hi.din_vld && hi.din_rdy) begin
      hq.push_back(hi.din);
      h_in_n++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    f_hold = 1'b0; f_hold_d = '0; f_last_d = '0;
    f_in_n = 0; f_out_n = 0; f_peak = 0;
    f_first_in = 0; f_first_out = 0; f_last_out = 0;
    h_in_n = 0; h_out_n = 0;
    rst = 1'b1;
    fi.din = '0; fi.din_vld = 1'b0; fi.dout_rdy = 1'b1;
    hi.din = '0; hi.din_vld = 1'b0; hi.dout_rdy = 1'b1;
    bi.din = '0; bi.din_vld = 1'b1; bi.dout_rdy = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_f_rdy", 64'(fi.din_rdy), 64'd0);
    chk("rst_f_vld", 64'(fi.dout_vld), 64'd0);
    chk("rst_f_dout", fi.dout, 64'd0);
    chk("rst_f_lvl", 64'(f_lvl), 64'd0);
    chk("rst_h_rdy", 64'(hi.din_rdy), 64'd0);
    chk("rst_b_rdy", 64'(bi.din_rdy), 64'd0);
    chk("rst_b_vld", 64'(bi.dout_vld), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_f_rdy", 64'(fi.din_rdy), 64'd1);
    chk("rel_h_rdy", 64'(hi.din_rdy), 64'd1);
    @(negedge clk);

    // FULL streaming, dout_rdy=1
    f_in_n = 0; f_out_n = 0; f_peak = 0;
    for (int k = 0; k < 8; k++) begin
      fi.din = 64'(k);
      fi.din_vld = 1'b1;
      tick();
    end
    fi.din_vld = 1'b0;
    repeat (4) tick();
    chk("s_in_n", 64'(f_in_n), 64'd8);
    chk("s_out_n", 64'(f_out_n), 64'd8);
    chk("s_latency", 64'(f_first_out - f_first_in), 64'd2);
    chk("s_consec", 64'(f_last_out - f_first_out), 64'd7);
    chk("s_peak", 64'(f_peak), 64'd2);

    // FULL fill with dout_rdy=0, then drain
    fi.dout_rdy = 1'b0;
    f_in_n = 0; f_out_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!fi.din_rdy) break;
      fi.din = 64'h100 + 64'(k);
      fi.din_vld = 1'b1;
      tick();
    end
    fi.din_vld = 1'b0;
    chk("fill_n", 64'(f_in_n), 64'd4);
    chk("fill_rdy", 64'(fi.din_rdy), 64'd0);
    chk("fill_lvl", 64'(f_lvl), 64'd4);
    chk("fill_head", fi.dout, 64'h100);
    repeat (2) tick();
    chk("fill_head2", fi.dout, 64'h100);
    fi.dout_rdy = 1'b1;
    repeat (6) tick();
    chk("drain_n", 64'(f_out_n), 64'd4);
    chk("drain_consec", 64'(f_last_out - f_first_out), 64'd3);
    chk("drain_lvl", 64'(f_lvl), 64'd0);

    // HALF, continuous valid and ready
    h_in_n = 0; h_out_n = 0;
    hi.din_vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pat[7-k] = hi.din_rdy;
      hi.din = 16'(h_in_n) + 16'h40;
      tick();
    end
    hi.din_vld = 1'b0;
    chk("h_rdy_toggle", 64'(pat), 64'hAA);
    chk("h_in_n", 64'(h_in_n), 64'd4);
    repeat (2) tick();
    chk("h_out_n", 64'(h_out_n), 64'd4);

    // BYPASS
    bi.din = 16'hA5A5;
    bi.din_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic r;
      r = (k % 2) == 1;
      bi.dout_rdy = r;
      #1;
      chk("b_dout", 64'(bi.dout), 64'hA5A5);
      chk("b_vld", 64'(bi.dout_vld), 64'd1);
      chk("b_rdy", 64'(bi.din_rdy), 64'(r));
      chk("b_lvl", 64'(b_lvl), 64'd0);
      @(negedge clk);
    end

    // FULL random traffic
    for (int k = 0; k < 10000; k++) begin
      fi.din_vld = 1'($urandom_range(0, 1));
      fi.dout_rdy = 1'($urandom_range(0, 1));
      fi.din = {$urandom(), $urandom()};
      tick();
    end
    fi.din_vld = 1'b0;
    fi.dout_rdy = 1'b1;
    repeat (8) tick();
    chk("rnd_empty", 64'(qf.size()), 64'd0);
    chk("rnd_lvl", 64'(f_lvl), 64'd0);

    // async reset with 3 beats held
    fi.dout_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fi.din = 64'h70 + 64'(k);
      fi.din_vld = 1'b1;
      tick();
    end
    fi.din_vld = 1'b0;
    chk("pre_rst_lvl", 64'(f_lvl), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", 64'(fi.dout_vld), 64'd0);
    chk("arst_lvl", 64'(f_lvl), 64'd0);
    chk("arst_rdy", 64'(fi.din_rdy), 64'd0);
    qf.delete();
    hq.delete();
    f_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_dout", fi.dout, 64'd0);
    rst = 1'b0;
    f_out_n = 0; f_in_n = 0;
    fi.din = 64'h1;
    fi.din_vld = 1'b1;
    fi.dout_rdy = 1'b1;
    tick();
    fi.din_vld = 1'b0;
    repeat (3) tick();
    chk("post_rst_n", 64'(f_out_n), 64'd1);
    chk("post_rst_d", f_last_d, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
